// File: rtl/scene_scheduler.sv
// Scene sequencer: draws rectangle geometry, colour and tone from a Galois LFSR into
// shadow registers on each second pulse, then commits them at the next frame boundary.
// Optional second rectangle is built when SCENE_SECOND_RECT_EN is defined.
module scene_scheduler #(
  parameter int          H_RES     = 640,
  parameter int          V_RES     = 480,
  parameter int          MIN_W     = 16,
  parameter int          MIN_H     = 16,
  parameter logic [15:0] TONE_BASE = 16'd12500,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_RETRY = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sec,
  input  logic        i_frame_start,
  output logic [9:0]  o_r0_x,
  output logic [8:0]  o_r0_y,
  output logic [9:0]  o_r0_w,
  output logic [8:0]  o_r0_h,
  output logic [5:0]  o_r0_col,
  output logic [9:0]  o_r1_x,
  output logic [8:0]  o_r1_y,
  output logic [9:0]  o_r1_w,
  output logic [8:0]  o_r1_h,
  output logic [5:0]  o_r1_col,
  output logic        o_r1_vld,
  output logic [15:0] o_tone_div,
  output logic        o_tone_en,
  output logic [7:0]  o_scene_cnt,
  output logic        o_busy,
  output logic        o_overrun
);

  localparam logic [15:0] LFSR_INIT  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam int          RW         = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_GEN_W, S_GEN_H, S_GEN_X, S_GEN_Y, S_GEN_COL, S_GEN_TONE, S_WAIT_FB, S_COMMIT
  } state_t;

  state_t        r_state;
  logic [15:0]   r_lfsr;
  logic [RW-1:0] r_retry;
  logic          r_pend;
  logic          r_busy;
  logic          r_overrun;

  logic [9:0]    r_cur_w;
  logic [8:0]    r_cur_h;
  logic [9:0]    r_cur_x;
  logic [8:0]    r_cur_y;

  logic [9:0]    r_sh0_x;
  logic [8:0]    r_sh0_y;
  logic [9:0]    r_sh0_w;
  logic [8:0]    r_sh0_h;
  logic [5:0]    r_sh0_col;
  logic [15:0]   r_sh_tone;

  logic [9:0]    r_r0_x;
  logic [8:0]    r_r0_y;
  logic [9:0]    r_r0_w;
  logic [8:0]    r_r0_h;
  logic [5:0]    r_r0_col;
  logic [15:0]   r_tone_div;
  logic          r_tone_en;
  logic [7:0]    r_scene_cnt;

`ifdef SCENE_SECOND_RECT_EN
  logic          r_idx;
  logic [9:0]    r_sh1_x;
  logic [8:0]    r_sh1_y;
  logic [9:0]    r_sh1_w;
  logic [8:0]    r_sh1_h;
  logic [5:0]    r_sh1_col;
  logic [9:0]    r_r1_x;
  logic [8:0]    r_r1_y;
  logic [9:0]    r_r1_w;
  logic [8:0]    r_r1_h;
  logic [5:0]    r_r1_col;
  logic          r_r1_vld;
`endif

  logic [15:0] w_lfsr_next;
  logic [9:0]  w_draw;
  logic [9:0]  w_w_cand;
  logic [8:0]  w_h_cand;
  logic        w_x_ok;
  logic        w_y_ok;
  logic [5:0]  w_col;
  logic [15:0] w_tone;
  logic        w_gen;

  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_draw      = r_lfsr[9:0];
  assign w_w_cand    = 10'(MIN_W) + {2'b00, w_draw[7:0]};
  assign w_h_cand    = 9'(MIN_H) + {1'b0, w_draw[7:0]};
  // Rejection sampling keeps every rectangle fully inside the visible area.
  assign w_x_ok      = (w_draw <= (10'(H_RES) - r_cur_w));
  assign w_y_ok      = (w_draw[8:0] <= (9'(V_RES) - r_cur_h));
  assign w_col       = (w_draw[5:0] == 6'h00) ? 6'h3F : w_draw[5:0];
  assign w_tone      = TONE_BASE + {3'b000, w_draw, 3'b000};
  assign w_gen       = r_state inside {S_GEN_W, S_GEN_H, S_GEN_X, S_GEN_Y, S_GEN_COL, S_GEN_TONE};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_lfsr      <= LFSR_INIT;
      r_retry     <= '0;
      r_pend      <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_cur_w     <= '0;
      r_cur_h     <= '0;
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_sh0_x     <= '0;
      r_sh0_y     <= '0;
      r_sh0_w     <= '0;
      r_sh0_h     <= '0;
      r_sh0_col   <= '0;
      r_sh_tone   <= '0;
      r_r0_x      <= '0;
      r_r0_y      <= '0;
      r_r0_w      <= '0;
      r_r0_h      <= '0;
      r_r0_col    <= '0;
      r_tone_div  <= '0;
      r_tone_en   <= 1'b0;
      r_scene_cnt <= '0;
`ifdef SCENE_SECOND_RECT_EN
      r_idx       <= 1'b0;
      r_sh1_x     <= '0;
      r_sh1_y     <= '0;
      r_sh1_w     <= '0;
      r_sh1_h     <= '0;
      r_sh1_col   <= '0;
      r_r1_x      <= '0;
      r_r1_y      <= '0;
      r_r1_w      <= '0;
      r_r1_h      <= '0;
      r_r1_col    <= '0;
      r_r1_vld    <= 1'b0;
`endif
    end else begin
      if (w_gen) begin
        r_lfsr <= w_lfsr_next;
      end

      // One second pulse may be queued while busy; a further one is dropped and flagged.
      if (i_sec && (r_state != S_IDLE) && (r_state != S_COMMIT)) begin
        if (r_pend) begin
          r_overrun <= 1'b1;
        end else begin
          r_pend <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_sec || r_pend) begin
            r_state <= S_GEN_W;
            r_busy  <= 1'b1;
            r_pend  <= 1'b0;
`ifdef SCENE_SECOND_RECT_EN
            r_idx   <= 1'b0;
`endif
          end
        end
        S_GEN_W: begin
          r_cur_w <= w_w_cand;
          r_state <= S_GEN_H;
        end
        S_GEN_H: begin
          r_cur_h <= w_h_cand;
          r_retry <= '0;
          r_state <= S_GEN_X;
        end
        S_GEN_X: begin
          if (w_x_ok || (r_retry == RETRY_LAST)) begin
            r_cur_x <= w_x_ok ? w_draw : 10'd0;
            r_retry <= '0;
            r_state <= S_GEN_Y;
          end else begin
            r_retry <= r_retry + 1'b1;
          end
        end
        S_GEN_Y: begin
          if (w_y_ok || (r_retry == RETRY_LAST)) begin
            r_cur_y <= w_y_ok ? w_draw[8:0] : 9'd0;
            r_retry <= '0;
            r_state <= S_GEN_COL;
          end else begin
            r_retry <= r_retry + 1'b1;
          end
        end
        S_GEN_COL: begin
`ifdef SCENE_SECOND_RECT_EN
          if (r_idx) begin
            r_sh1_x   <= r_cur_x;
            r_sh1_y   <= r_cur_y;
            r_sh1_w   <= r_cur_w;
            r_sh1_h   <= r_cur_h;
            r_sh1_col <= w_col;
            r_state   <= S_GEN_TONE;
          end else begin
            r_sh0_x   <= r_cur_x;
            r_sh0_y   <= r_cur_y;
            r_sh0_w   <= r_cur_w;
            r_sh0_h   <= r_cur_h;
            r_sh0_col <= w_col;
            r_idx     <= 1'b1;
            r_state   <= S_GEN_W;
          end
`else
          r_sh0_x   <= r_cur_x;
          r_sh0_y   <= r_cur_y;
          r_sh0_w   <= r_cur_w;
          r_sh0_h   <= r_cur_h;
          r_sh0_col <= w_col;
          r_state   <= S_GEN_TONE;
`endif
        end
        S_GEN_TONE: begin
          r_sh_tone <= w_tone;
          r_state   <= S_WAIT_FB;
        end
        S_WAIT_FB: begin
          // Outputs change only at a frame boundary so the picture never tears.
          if (i_frame_start) begin
            r_r0_x      <= r_sh0_x;
            r_r0_y      <= r_sh0_y;
            r_r0_w      <= r_sh0_w;
            r_r0_h      <= r_sh0_h;
            r_r0_col    <= r_sh0_col;
            r_tone_div  <= r_sh_tone;
            r_tone_en   <= 1'b1;
            r_scene_cnt <= r_scene_cnt + 8'd1;
`ifdef SCENE_SECOND_RECT_EN
            r_r1_x      <= r_sh1_x;
            r_r1_y      <= r_sh1_y;
            r_r1_w      <= r_sh1_w;
            r_r1_h      <= r_sh1_h;
            r_r1_col    <= r_sh1_col;
            r_r1_vld    <= 1'b1;
`endif
            r_state     <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          // A queued pulse and a fresh one together: start one scene, keep the other queued.
          if (r_pend || i_sec) begin
            r_state <= S_GEN_W;
            r_pend  <= r_pend & i_sec;
`ifdef SCENE_SECOND_RECT_EN
            r_idx   <= 1'b0;
`endif
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_r0_x      = r_r0_x;
  assign o_r0_y      = r_r0_y;
  assign o_r0_w      = r_r0_w;
  assign o_r0_h      = r_r0_h;
  assign o_r0_col    = r_r0_col;
  assign o_tone_div  = r_tone_div;
  assign o_tone_en   = r_tone_en;
  assign o_scene_cnt = r_scene_cnt;
  assign o_busy      = r_busy;
  assign o_overrun   = r_overrun;

`ifdef SCENE_SECOND_RECT_EN
  assign o_r1_x   = r_r1_x;
  assign o_r1_y   = r_r1_y;
  assign o_r1_w   = r_r1_w;
  assign o_r1_h   = r_r1_h;
  assign o_r1_col = r_r1_col;
  assign o_r1_vld = r_r1_vld;
`else
  assign o_r1_x   = '0;
  assign o_r1_y   = '0;
  assign o_r1_w   = '0;
  assign o_r1_h   = '0;
  assign o_r1_col = '0;
  assign o_r1_vld = 1'b0;
`endif

endmodule

// File: tb/tb_scene_scheduler.sv
// Bench for scene_scheduler: three instances (SEED=ACE1, 0, 1) against a scene-level model,
// plus a small vector table and hand-written pend/overrun/reset sequences.
module tb_scene_scheduler;

`ifdef SCENE_SECOND_RECT_EN
  localparam int NRECT = 2;
`else
  localparam int NRECT = 1;
`endif
  localparam int NDUT = 3;

  typedef struct packed {
    logic [9:0]  x0;
    logic [8:0]  y0;
    logic [9:0]  w0;
    logic [8:0]  h0;
    logic [5:0]  c0;
    logic [9:0]  x1;
    logic [8:0]  y1;
    logic [9:0]  w1;
    logic [8:0]  h1;
    logic [5:0]  c1;
    logic        vld1;
    logic [15:0] tone;
  } scene_t;

  typedef struct {
    logic [15:0] lfsr;
    int          phase;   // 0 idle, 1 generating, 2 waiting for frame, 3 commit
    int          g;
    bit          pend;
    bit          ovr;
    scene_t      sh;
    scene_t      act;
    bit          ten;
    logic [7:0]  cnt;
  } model_t;

  typedef struct {
    int         cyc;
    bit         busy;
    logic [7:0] cnt;
    bit         ten;
    bit         w_set;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic sec_in;
  logic fs_in;

  logic [9:0]  d_r0_x [NDUT];
  logic [8:0]  d_r0_y [NDUT];
  logic [9:0]  d_r0_w [NDUT];
  logic [8:0]  d_r0_h [NDUT];
  logic [5:0]  d_r0_col [NDUT];
  logic [9:0]  d_r1_x [NDUT];
  logic [8:0]  d_r1_y [NDUT];
  logic [9:0]  d_r1_w [NDUT];
  logic [8:0]  d_r1_h [NDUT];
  logic [5:0]  d_r1_col [NDUT];
  logic        d_r1_vld [NDUT];
  logic [15:0] d_tone_div [NDUT];
  logic        d_tone_en [NDUT];
  logic [7:0]  d_scene_cnt [NDUT];
  logic        d_busy [NDUT];
  logic        d_overrun [NDUT];

  int     total = 0;
  int     bad = 0;
  model_t m [2];
  bit     last_commit;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      scene_scheduler #(
        .SEED((gi == 0) ? 16'hACE1 : ((gi == 1) ? 16'h0000 : 16'h0001))
      ) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sec        (sec_in),
        .i_frame_start(fs_in),
        .o_r0_x       (d_r0_x[gi]),
        .o_r0_y       (d_r0_y[gi]),
        .o_r0_w       (d_r0_w[gi]),
        .o_r0_h       (d_r0_h[gi]),
        .o_r0_col     (d_r0_col[gi]),
        .o_r1_x       (d_r1_x[gi]),
        .o_r1_y       (d_r1_y[gi]),
        .o_r1_w       (d_r1_w[gi]),
        .o_r1_h       (d_r1_h[gi]),
        .o_r1_col     (d_r1_col[gi]),
        .o_r1_vld     (d_r1_vld[gi]),
        .o_tone_div   (d_tone_div[gi]),
        .o_tone_en    (d_tone_en[gi]),
        .o_scene_cnt  (d_scene_cnt[gi]),
        .o_busy       (d_busy[gi]),
        .o_overrun    (d_overrun[gi])
      );
    end
  endgenerate

  function automatic logic [15:0] lstep(logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Whole-scene generator: returns the scene and how many draw cycles it consumed.
  function automatic scene_t gen_scene(inout logic [15:0] l, output int n);
    scene_t s;
    int w, h, x, y, c, d;
    bit done;
    s = '0;
    n = 0;
    for (int r = 0; r < NRECT; r++) begin
      w = 16 + int'(l[7:0]); l = lstep(l); n++;
      h = 16 + int'(l[7:0]); l = lstep(l); n++;
      x = 0; done = 0;
      for (int t = 0; t < 4; t++) begin
        if (!done) begin
          d = int'(l[9:0]); l = lstep(l); n++;
          if (d <= 640 - w) begin x = d; done = 1; end
        end
      end
      y = 0; done = 0;
      for (int t = 0; t < 4; t++) begin
        if (!done) begin
          d = int'(l[8:0]); l = lstep(l); n++;
          if (d <= 480 - h) begin y = d; done = 1; end
        end
      end
      c = int'(l[5:0]); if (c == 0) c = 63; l = lstep(l); n++;
      if (r == 0) begin
        s.x0 = 10'(x); s.y0 = 9'(y); s.w0 = 10'(w); s.h0 = 9'(h); s.c0 = 6'(c);
      end else begin
        s.x1 = 10'(x); s.y1 = 9'(y); s.w1 = 10'(w); s.h1 = 9'(h); s.c1 = 6'(c);
      end
    end
    s.vld1 = (NRECT == 2);
    s.tone = 16'(12500 + 8 * int'(l[9:0])); l = lstep(l); n++;
    return s;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].lfsr = (i == 0) ? 16'hACE1 : 16'h0001;
      m[i].phase = 0; m[i].g = 0; m[i].pend = 0; m[i].ovr = 0;
      m[i].sh = '0; m[i].act = '0; m[i].ten = 0; m[i].cnt = '0;
    end
  endfunction

  function automatic void sec_rule(int i, bit sec);
    if (sec) begin
      if (m[i].pend) m[i].ovr = 1; else m[i].pend = 1;
    end
  endfunction

  function automatic bit mstep(int i, bit sec, bit fs);
    bit start = 0;
    bit commit = 0;
    int n;
    logic [15:0] l;
    case (m[i].phase)
      0: begin start = sec || m[i].pend; m[i].pend = 0; end
      1: begin
        sec_rule(i, sec);
        m[i].g--;
        if (m[i].g == 0) m[i].phase = 2;
      end
      2: begin
        sec_rule(i, sec);
        if (fs) begin
          m[i].act = m[i].sh; m[i].ten = 1; m[i].cnt = m[i].cnt + 8'd1;
          m[i].phase = 3; commit = 1;
        end
      end
      default: begin
        start = m[i].pend || sec;
        m[i].pend = m[i].pend && sec;
        if (!start) m[i].phase = 0;
      end
    endcase
    if (start) begin
      l = m[i].lfsr;
      m[i].sh = gen_scene(l, n);
      m[i].lfsr = l;
      m[i].g = n;
      m[i].phase = 1;
    end
    return commit;
  endfunction

  function automatic logic [115:0] pack_dut(int k);
    return {d_r0_x[k], d_r0_y[k], d_r0_w[k], d_r0_h[k], d_r0_col[k],
            d_r1_x[k], d_r1_y[k], d_r1_w[k], d_r1_h[k], d_r1_col[k], d_r1_vld[k],
            d_tone_div[k], d_tone_en[k], d_scene_cnt[k], d_busy[k], d_overrun[k]};
  endfunction

  function automatic logic [115:0] pack_model(int i);
    return {m[i].act, m[i].ten, m[i].cnt, (m[i].phase != 0), m[i].ovr};
  endfunction

  function automatic void chk_vec(string name, logic [115:0] act, logic [115:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_int(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check_all();
    for (int k = 0; k < NDUT; k++) begin
      chk_vec($sformatf("dut%0d_outputs", k), pack_dut(k), pack_model((k == 0) ? 0 : 1));
    end
  endfunction

  task automatic cycle(input bit s, input bit f);
    sec_in = s;
    fs_in = f;
    @(posedge clk);
    last_commit = 0;
    if (rst_n) begin
      last_commit = mstep(0, s, f);
      void'(mstep(1, s, f));
    end else begin
      model_reset();
    end
    @(negedge clk);
    sec_in = 0;
    fs_in = 0;
    check_all();
  endtask

  task automatic check_invariants();
    chk_int("inv_x_plus_w", int'(d_r0_x[0]) + int'(d_r0_w[0]) <= 640, 1);
    chk_int("inv_y_plus_h", int'(d_r0_y[0]) + int'(d_r0_h[0]) <= 480, 1);
    chk_int("inv_w_min", d_r0_w[0] >= 10'd16, 1);
    chk_int("inv_h_min", d_r0_h[0] >= 9'd16, 1);
    chk_int("inv_col_nonzero", d_r0_col[0] != 6'h00, 1);
    chk_int("inv_tone_min", d_tone_div[0] >= 16'd12500, 1);
    if (NRECT == 2) begin
      chk_int("inv_r1_x_plus_w", int'(d_r1_x[0]) + int'(d_r1_w[0]) <= 640, 1);
      chk_int("inv_r1_y_plus_h", int'(d_r1_y[0]) + int'(d_r1_h[0]) <= 480, 1);
    end
  endtask

  initial begin
    vec_t   vecs [6];
    scene_t first_scene;
    int     gap, commits, cyc;
    bit     saw_wrap;

    vecs[0] = '{cyc: 10,  busy: 0, cnt: 8'd0, ten: 0, w_set: 0};
    vecs[1] = '{cyc: 11,  busy: 1, cnt: 8'd0, ten: 0, w_set: 0};
    vecs[2] = '{cyc: 200, busy: 1, cnt: 8'd0, ten: 0, w_set: 0};
    vecs[3] = '{cyc: 201, busy: 1, cnt: 8'd1, ten: 1, w_set: 1};
    vecs[4] = '{cyc: 202, busy: 0, cnt: 8'd1, ten: 1, w_set: 1};
    vecs[5] = '{cyc: 250, busy: 0, cnt: 8'd1, ten: 1, w_set: 1};

    rst_n = 1'b0;
    sec_in = 1'b0;
    fs_in = 1'b0;
    last_commit = 0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) chk_vec($sformatf("reset_state_dut%0d", k), pack_dut(k), '0);
    rst_n = 1'b1;

    // Idle after reset: nothing moves.
    repeat (100) cycle(0, 0);
    chk_int("idle_busy", d_busy[0], 0);
    chk_int("idle_overrun", d_overrun[0], 0);
    chk_int("idle_tone_en", d_tone_en[0], 0);

    // Single scene: sec at cycle 10, frame_start at cycle 200.
    for (int c = 0; c <= 260; c++) begin
      cycle(c == 10, c == 200);
      for (int v = 0; v < 6; v++) begin
        if (vecs[v].cyc == c + 1) begin
          chk_int($sformatf("vec%0d_busy", v), d_busy[0], vecs[v].busy);
          chk_int($sformatf("vec%0d_cnt", v), d_scene_cnt[0], vecs[v].cnt);
          chk_int($sformatf("vec%0d_tone_en", v), d_tone_en[0], vecs[v].ten);
          chk_int($sformatf("vec%0d_w_set", v), d_r0_w[0] != 10'd0, vecs[v].w_set);
        end
      end
    end
    chk_int("first_tone_min", d_tone_div[0] >= 16'd12500, 1);
    chk_int("r1_vld_seed0", d_r1_vld[1], NRECT == 2);
    chk_int("r1_vld_seed1", d_r1_vld[2], NRECT == 2);
    first_scene = m[0].act;

    // Two extra pulses during one WAIT_FB: first queues, second overruns.
    cycle(1, 0);
    repeat (40) cycle(0, 0);
    chk_int("wait_busy", d_busy[0], 1);
    cycle(1, 0);
    chk_int("pend_no_overrun", d_overrun[0], 0);
    cycle(1, 0);
    chk_int("second_pulse_overrun", d_overrun[0], 1);
    repeat (3) cycle(0, 0);
    cycle(0, 1);
    chk_int("commit_cnt", d_scene_cnt[0], 2);
    chk_int("commit_busy", d_busy[0], 1);
    cycle(0, 0);
    chk_int("pend_restart_busy", d_busy[0], 1);
    repeat (40) cycle(0, 0);
    cycle(0, 1);
    cycle(0, 0);
    cycle(0, 0);
    chk_int("pend_scene_cnt", d_scene_cnt[0], 3);
    chk_int("pend_scene_idle", d_busy[0], 0);
    chk_int("overrun_sticky", d_overrun[0], 1);

    // Reset while in GEN_X, then a fresh scene must match the first one from SEED.
    cycle(1, 0);
    cycle(0, 0);
    cycle(0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < NDUT; k++) chk_vec($sformatf("midreset_dut%0d", k), pack_dut(k), '0);
    cycle(0, 0);
    cycle(0, 0);
    rst_n = 1'b1;
    repeat (10) cycle(0, 0);
    chk_vec("reset_hold_zero", pack_dut(0), '0);
    cycle(1, 0);
    repeat (40) cycle(0, 0);
    cycle(0, 1);
    chk_vec("fresh_scene_match", {d_r0_x[0], d_r0_y[0], d_r0_w[0], d_r0_h[0], d_r0_col[0],
             d_r1_x[0], d_r1_y[0], d_r1_w[0], d_r1_h[0], d_r1_col[0], d_r1_vld[0],
             d_tone_div[0], 11'd0}, {first_scene, 11'd0});
    chk_int("fresh_cnt", d_scene_cnt[0], 1);
    chk_int("fresh_overrun", d_overrun[0], 0);
    cycle(0, 0);

    // Randomized run until the scene counter has wrapped.
    gap = 0; commits = 0; cyc = 0; saw_wrap = 0;
    while (commits < 300 && cyc < 60000) begin
      bit s;
      s = (gap == 0);
      if (s) gap = $urandom_range(45, 120); else gap--;
      cycle(s, $urandom_range(0, 15) == 0);
      cyc++;
      if (last_commit) begin
        commits++;
        check_invariants();
        if (m[0].cnt == 8'd0) begin
          saw_wrap = 1;
          chk_int("wrap_cnt_zero", d_scene_cnt[0], 0);
        end
      end
    end
    chk_int("random_commits_reached", commits >= 300, 1);
    chk_int("scene_cnt_wrapped", saw_wrap, 1);
    chk_int("final_r1_vld", d_r1_vld[0], NRECT == 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
